// File: rtl/race_heat_scheduler_if.sv
// ---------------------------------------------------------------------------
// race_heat_scheduler_if
//   Host and lane handshake bundle for race_heat_scheduler.
//
//   Host side : go, lane_en, result_ack (to DUT);
//               busy, result_valid, winner, winner_time, finish_mask,
//               timeout, false_start (from DUT)
//   Lane side : lane_ready, lane_done (to DUT); start (from DUT)
//
//   modport master : the host/lanes environment driving the scheduler
//   modport slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface race_heat_scheduler_if #(
    parameter int LANES   = 4,
    parameter int TIMER_W = 16
);
    localparam int WIN_W = $clog2(LANES);

    logic               go;
    logic [LANES-1:0]   lane_en;
    logic [LANES-1:0]   lane_ready;
    logic [LANES-1:0]   lane_done;
    logic               result_ack;
    logic               start;
    logic               busy;
    logic               result_valid;
    logic [WIN_W-1:0]   winner;
    logic [TIMER_W-1:0] winner_time;
    logic [LANES-1:0]   finish_mask;
    logic               timeout;
    logic               false_start;

    modport master (
        output go, lane_en, lane_ready, lane_done, result_ack,
        input  start, busy, result_valid, winner, winner_time,
               finish_mask, timeout, false_start
    );

    modport slave (
        input  go, lane_en, lane_ready, lane_done, result_ack,
        output start, busy, result_valid, winner, winner_time,
               finish_mask, timeout, false_start
    );
endinterface

// File: rtl/race_heat_scheduler.sv
// ---------------------------------------------------------------------------
// race_heat_scheduler
//   Sequences one heat across up to LANES racer lanes: arm on go, wait for
//   every enabled lane to be ready, broadcast start, time each lane's done
//   with a saturating cycle timer, record finish order/winner, and hold the
//   results until the host acknowledges and all lanes are back to idle.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_l : asynchronous active-low reset
//     bus   : race_heat_scheduler_if.slave (host + lane handshake)
//
//   Optional feature: define FALSE_START_DET_EN to abort a heat when an
//   active lane shows done while ARMED (false_start = 1). When undefined,
//   done in ARMED is ignored and false_start is tied to 0.
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module race_heat_scheduler #(
    parameter int          LANES    = 4,
    parameter int          TIMER_W  = 16,
    parameter int unsigned MAX_TIME = 32'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_l,
    race_heat_scheduler_if.slave bus
);
    localparam int                 WIN_W = $clog2(LANES);
    localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_TIME);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [LANES-1:0]   active, active_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic               ack_seen, ack_seen_n;
    logic               start, start_n;
    logic               busy, busy_n;
    logic               result_valid, result_valid_n;
    logic [WIN_W-1:0]   winner, winner_n;
    logic [TIMER_W-1:0] winner_time, winner_time_n;
    logic [LANES-1:0]   finish_mask, finish_mask_n;
    logic               timeout, timeout_n;
    logic               false_start, false_start_n;

    logic [LANES-1:0]   done_act;
    logic [LANES-1:0]   new_done;
    logic [LANES-1:0]   fm_next;

    // Lowest set index; simultaneous finishers resolve to the smallest lane.
    function automatic logic [WIN_W-1:0] lowest(input logic [LANES-1:0] v);
        lowest = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) lowest = WIN_W'(i);
        end
    endfunction

    assign done_act = bus.lane_done & active;
    assign new_done = done_act & ~finish_mask;
    assign fm_next  = finish_mask | done_act;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_n        = state;
        active_n       = active;
        timer_n        = timer;
        ack_seen_n     = ack_seen;
        start_n        = start;
        result_valid_n = result_valid;
        winner_n       = winner;
        winner_time_n  = winner_time;
        finish_mask_n  = finish_mask;
        timeout_n      = timeout;
        false_start_n  = false_start;

        case (state)
            S_IDLE: begin
                ack_seen_n = 1'b0;
                if (bus.go && (bus.lane_en != '0)) begin
                    active_n      = bus.lane_en;
                    finish_mask_n = '0;
                    winner_n      = '0;
                    winner_time_n = '0;
                    timeout_n     = 1'b0;
                    false_start_n = 1'b0;
                    state_n       = S_ARMED;
                end
            end

            S_ARMED: begin
`ifdef FALSE_START_DET_EN
                if (done_act != '0) begin
                    // Early done aborts the heat; start is never raised.
                    false_start_n  = 1'b1;
                    finish_mask_n  = done_act;
                    winner_n       = lowest(done_act);
                    winner_time_n  = '0;
                    result_valid_n = 1'b1;
                    state_n        = S_RESULT;
                end else
`endif
                if ((bus.lane_ready & active) == active) begin
                    start_n = 1'b1;
                    timer_n = '0;
                    state_n = S_RUN;
                end
            end

            S_RUN: begin
                timer_n       = (timer == MAX_T) ? timer : timer + 1'b1;
                finish_mask_n = fm_next;
                // First finisher of the heat: nothing recorded yet.
                if ((finish_mask == '0) && (new_done != '0)) begin
                    winner_n      = lowest(new_done);
                    winner_time_n = timer;
                end
                if (((fm_next & active) == active) || (timer == MAX_T)) begin
                    if ((fm_next & active) != active) begin
                        timeout_n = 1'b1;
                        if (fm_next == '0) begin
                            winner_n      = '0;
                            winner_time_n = MAX_T;
                        end
                    end
                    start_n        = 1'b0;
                    result_valid_n = 1'b1;
                    state_n        = S_RESULT;
                end
            end

            S_RESULT: begin
                // Ack is remembered so the host may acknowledge before
                // the lanes have released.
                ack_seen_n = ack_seen | bus.result_ack;
                if ((ack_seen | bus.result_ack) &&
                    (((bus.lane_done | bus.lane_ready) & active) == '0)) begin
                    ack_seen_n     = 1'b0;
                    result_valid_n = 1'b0;
                    state_n        = S_IDLE;
                end
            end

            default: begin
                state_n        = S_IDLE;
                active_n       = '0;
                timer_n        = '0;
                ack_seen_n     = 1'b0;
                start_n        = 1'b0;
                result_valid_n = 1'b0;
                winner_n       = '0;
                winner_time_n  = '0;
                finish_mask_n  = '0;
                timeout_n      = 1'b0;
                false_start_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= S_IDLE;
            active       <= '0;
            timer        <= '0;
            ack_seen     <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= '0;
            winner_time  <= '0;
            finish_mask  <= '0;
            timeout      <= 1'b0;
            false_start  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state        <= state_n;
            active       <= active_n;
            timer        <= timer_n;
            ack_seen     <= ack_seen_n;
            start        <= start_n;
            busy         <= busy_n;
            result_valid <= result_valid_n;
            winner       <= winner_n;
            winner_time  <= winner_time_n;
            finish_mask  <= finish_mask_n;
            timeout      <= timeout_n;
            false_start  <= false_start_n;
        end
    end

    assign bus.start        = start;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.winner       = winner;
    assign bus.winner_time  = winner_time;
    assign bus.finish_mask  = finish_mask;
    assign bus.timeout      = timeout;
`ifdef FALSE_START_DET_EN
    assign bus.false_start  = false_start;
`else
    assign bus.false_start  = 1'b0;
`endif

endmodule

// File: tb/tb_race_heat_scheduler.sv
// ---------------------------------------------------------------------------
// tb_race_heat_scheduler
//   Directed bench for race_heat_scheduler (LANES=4, TIMER_W=16,
//   MAX_TIME=20). Inputs are driven and outputs sampled on the falling edge.
//   Honours FALSE_START_DET_EN for the false-start heat.
// ---------------------------------------------------------------------------
module tb_race_heat_scheduler;
    logic clk = 1'b0;
    logic rst_l;
    int   n_checks = 0;
    int   n_errors = 0;

    race_heat_scheduler_if #(.LANES(4), .TIMER_W(16)) bus ();

    race_heat_scheduler #(
        .LANES    (4),
        .TIMER_W  (16),
        .MAX_TIME (20)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Arm a heat with the given enables/ready levels and step into the
    // first RUN cycle (timer = 0).
    task automatic arm_and_start(input logic [3:0] en, input logic [3:0] rdy,
                                 input string tag);
        bus.go         = 1'b1;
        bus.lane_en    = en;
        bus.lane_ready = rdy;
        step(1);
        bus.go = 1'b0;
        step(1);
        check({tag, "_start"}, 32'(bus.start), 1);
    endtask

    // Ack and drop all lane levels together; one edge back to IDLE.
    task automatic release_lanes(input string tag);
        bus.result_ack = 1'b1;
        bus.lane_done  = '0;
        bus.lane_ready = '0;
        step(1);
        bus.result_ack = 1'b0;
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.go         = 1'b0;
        bus.lane_en    = '0;
        bus.lane_ready = '0;
        bus.lane_done  = '0;
        bus.result_ack = 1'b0;
        rst_l          = 1'b0;
        step(2);

        // Reset state
        check("rst_start",        32'(bus.start),        0);
        check("rst_busy",         32'(bus.busy),         0);
        check("rst_result_valid", 32'(bus.result_valid), 0);
        check("rst_winner",       32'(bus.winner),       0);
        check("rst_winner_time",  32'(bus.winner_time),  0);
        check("rst_finish_mask",  32'(bus.finish_mask),  0);
        check("rst_timeout",      32'(bus.timeout),      0);
        check("rst_false_start",  32'(bus.false_start),  0);
        rst_l = 1'b1;
        step(1);

        // go with no lanes enabled is ignored
        bus.go      = 1'b1;
        bus.lane_en = 4'b0000;
        step(1);
        bus.go = 1'b0;
        check("go_en0_ignored", 32'(bus.busy), 0);

        // Heat 1: all lanes, ready one cycle late, lane 2 wins at t=10
        bus.lane_en = 4'b1111;
        bus.go      = 1'b1;
        step(1);
        bus.go = 1'b0;
        check("h1_armed_busy",  32'(bus.busy),  1);
        check("h1_armed_start", 32'(bus.start), 0);
        step(1);
        check("h1_wait_ready_start", 32'(bus.start), 0);
        bus.lane_ready = 4'b1111;
        step(1);
        check("h1_start", 32'(bus.start), 1);
        step(10);
        bus.lane_done = 4'b0100;
        step(1);
        check("h1_fm_partial",   32'(bus.finish_mask),  'h4);
        check("h1_winner",       32'(bus.winner),       2);
        check("h1_winner_time",  32'(bus.winner_time),  10);
        check("h1_rv_running",   32'(bus.result_valid), 0);
        check("h1_start_held",   32'(bus.start),        1);
        bus.lane_done = 4'b1111;
        step(1);
        check("h1_result_valid", 32'(bus.result_valid), 1);
        check("h1_start_low",    32'(bus.start),        0);
        check("h1_fm_all",       32'(bus.finish_mask),  'hF);
        check("h1_winner_keep",  32'(bus.winner),       2);
        check("h1_wt_keep",      32'(bus.winner_time),  10);
        check("h1_timeout",      32'(bus.timeout),      0);
        // Ack while lanes still report done: must stay in RESULT
        bus.result_ack = 1'b1;
        step(1);
        bus.result_ack = 1'b0;
        check("h1_ack_early_busy", 32'(bus.busy),         1);
        check("h1_ack_early_rv",   32'(bus.result_valid), 1);
        bus.lane_done  = '0;
        bus.lane_ready = '0;
        step(1);
        check("h1_release_busy", 32'(bus.busy),         0);
        check("h1_release_rv",   32'(bus.result_valid), 0);
        check("h1_idle_winner",  32'(bus.winner),       2);

        // Heat 2: lanes 1 and 3 tie at t=3
        arm_and_start(4'b1111, 4'b1111, "h2");
        step(3);
        bus.lane_done = 4'b1010;
        step(1);
        check("h2_fm_tie",      32'(bus.finish_mask), 'hA);
        check("h2_winner_tie",  32'(bus.winner),      1);
        check("h2_winner_time", 32'(bus.winner_time), 3);
        bus.lane_done = 4'b1111;
        step(1);
        check("h2_result_valid", 32'(bus.result_valid), 1);
        check("h2_winner_keep",  32'(bus.winner),       1);
        release_lanes("h2");

        // Heat 3: only lanes 0/2 enabled, minimum path, winner_time = 0
        arm_and_start(4'b0101, 4'b0101, "h3");
        bus.lane_done = 4'b0101;
        step(1);
        check("h3_result_valid", 32'(bus.result_valid), 1);
        check("h3_fm",           32'(bus.finish_mask),  'h5);
        check("h3_winner",       32'(bus.winner),       0);
        check("h3_winner_time",  32'(bus.winner_time),  0);
        check("h3_timeout",      32'(bus.timeout),      0);
        release_lanes("h3");

        // Heat 4: only lane 0 finishes (t=5); timeout after timer hits 20
        arm_and_start(4'b1111, 4'b1111, "h4");
        step(5);
        bus.lane_done = 4'b0001;
        step(15);
        check("h4_pre_timeout_rv",    32'(bus.result_valid), 0);
        check("h4_pre_timeout_start", 32'(bus.start),        1);
        step(1);
        check("h4_result_valid", 32'(bus.result_valid), 1);
        check("h4_timeout",      32'(bus.timeout),      1);
        check("h4_fm",           32'(bus.finish_mask),  'h1);
        check("h4_winner",       32'(bus.winner),       0);
        check("h4_winner_time",  32'(bus.winner_time),  5);
        check("h4_start_low",    32'(bus.start),        0);
        release_lanes("h4");

        // Heat 5: lane 1 only, never finishes -> winner 0, time MAX_TIME
        arm_and_start(4'b0010, 4'b0010, "h5");
        step(21);
        check("h5_result_valid", 32'(bus.result_valid), 1);
        check("h5_timeout",      32'(bus.timeout),      1);
        check("h5_fm",           32'(bus.finish_mask),  0);
        check("h5_winner",       32'(bus.winner),       0);
        check("h5_winner_time",  32'(bus.winner_time),  20);
        release_lanes("h5");

        // Heat 6: reset mid-RUN drops start without a clock edge
        arm_and_start(4'b1111, 4'b1111, "h6");
        step(3);
        #2 rst_l = 1'b0;
        #1;
        check("h6_rst_start", 32'(bus.start),        0);
        check("h6_rst_busy",  32'(bus.busy),         0);
        check("h6_rst_rv",    32'(bus.result_valid), 0);
        step(1);
        bus.lane_ready = '0;
        rst_l          = 1'b1;
        step(1);
        check("h6_after_rst_busy", 32'(bus.busy), 0);

        // Heat 7: lane 3 shows done while ARMED
        bus.go         = 1'b1;
        bus.lane_en    = 4'b1111;
        bus.lane_ready = 4'b0000;
        step(1);
        bus.go        = 1'b0;
        bus.lane_done = 4'b1000;
        step(1);
`ifdef FALSE_START_DET_EN
        check("h7_false_start",  32'(bus.false_start),  1);
        check("h7_result_valid", 32'(bus.result_valid), 1);
        check("h7_winner",       32'(bus.winner),       3);
        check("h7_fm",           32'(bus.finish_mask),  'h8);
        check("h7_winner_time",  32'(bus.winner_time),  0);
        check("h7_start",        32'(bus.start),        0);
        release_lanes("h7");
`else
        check("h7_false_start", 32'(bus.false_start), 0);
        check("h7_start_armed", 32'(bus.start),       0);
        check("h7_busy_armed",  32'(bus.busy),        1);
        bus.lane_ready = 4'b1111;
        step(1);
        check("h7_start", 32'(bus.start), 1);
        step(1);
        check("h7_fm",          32'(bus.finish_mask), 'h8);
        check("h7_winner",      32'(bus.winner),      3);
        check("h7_winner_time", 32'(bus.winner_time), 0);
        bus.lane_done = 4'b1111;
        step(1);
        check("h7_result_valid", 32'(bus.result_valid), 1);
        check("h7_no_false",     32'(bus.false_start),  0);
        release_lanes("h7");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
